// File: rtl/synth_pkg.sv
// Shared types and constants for the melody sequencer slice.
// Optional feature macro used by the sequencer: SEQ_LOOP_EN.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       rest;
        logic [5:0] note;
        logic [3:0] dur;
    } step_t;

    localparam logic [5:0] NOTE_A4 = 6'b000101;
    localparam logic [3:0] DUR_END = 4'd0;

endpackage

// File: rtl/melody_sequencer_tempo_tick.sv
// tempo_tick: DIV-cycle prescaler with synchronous clear.
// tick is high for exactly one cycle out of every DIV enabled cycles.
module tempo_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Count 0..DIV-1 while enabled; clear forces the count back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a programmable pattern into the note-code path,
// or passes the manual switches through when idle.
// Build option: define SEQ_LOOP_EN to repeat the pattern until stop;
// without it the sequencer returns to IDLE at the end of the pattern.
module melody_sequencer
    import synth_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 16,
    parameter int STEPS   = 16,
    localparam int AW     = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [10:0]   wr_data,
    input  logic [5:0]    manual_sw,
    output logic [5:0]    note_code,
    output logic          gate,
    output logic          busy,
    output logic [AW-1:0] step_idx
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    if (DIV < 1) begin : g_div_check
        $error("melody_sequencer: CLK_HZ/TICK_HZ must be at least 1");
    end
    if (STEPS < 2 || (STEPS & (STEPS - 1)) != 0) begin : g_steps_check
        $error("melody_sequencer: STEPS must be a power of two >= 2");
    end

`ifndef SEQ_LOOP_EN
    localparam logic [AW-1:0] LAST_IDX = AW'(STEPS - 1);
`endif

    seq_state_t    state;
    seq_state_t    state_nx;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nx;
    logic [3:0]    remaining;
    logic          load_play;
    logic          tick;
    step_t         word;
    logic [10:0]   mem [STEPS];

    assign word = mem[idx];

    tempo_tick #(
        .DIV (DIV)
    ) u_tempo_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != PLAY),
        .enable (state == PLAY),
        .tick   (tick)
    );

    // Next-state and step index selection; stop overrides everything.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        load_play = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    idx_nx   = '0;
                end
            end
            FETCH: begin
                if (word.dur == DUR_END) begin
                    if (idx == '0) begin
                        state_nx = IDLE;
                    end else begin
`ifdef SEQ_LOOP_EN
                        state_nx = FETCH;
                        idx_nx   = '0;
`else
                        state_nx = IDLE;
`endif
                    end
                end else begin
                    state_nx  = PLAY;
                    load_play = 1'b1;
                end
            end
            PLAY: begin
                if (tick && remaining == 4'd1) begin
`ifdef SEQ_LOOP_EN
                    state_nx = FETCH;
                    idx_nx   = idx + 1'b1;
`else
                    if (idx == LAST_IDX) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = FETCH;
                        idx_nx   = idx + 1'b1;
                    end
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
        if (stop) begin
            state_nx  = IDLE;
            load_play = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Step datapath and registered outputs: passthrough in IDLE, step load on PLAY entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            remaining <= 4'd0;
            note_code <= NOTE_A4;
            gate      <= 1'b0;
            busy      <= 1'b0;
            step_idx  <= '0;
        end else begin
            idx  <= idx_nx;
            busy <= (state_nx != IDLE);
            if (state == IDLE) begin
                note_code <= manual_sw;
                gate      <= 1'b1;
            end
            if (load_play) begin
                step_idx  <= idx;
                remaining <= word.dur;
                if (word.rest) begin
                    gate <= 1'b0;
                end else begin
                    note_code <= word.note;
                    gate      <= 1'b1;
                end
            end else if (state == PLAY && tick) begin
                remaining <= remaining - 4'd1;
            end
        end
    end

    // Pattern memory; a write lands at the clock edge, so a same-cycle fetch sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with CLK_HZ=16, TICK_HZ=4 (DIV=4).
// Honours SEQ_LOOP_EN the same way the design does.
module tb_melody_sequencer;

    localparam int CLK_HZ  = 16;
    localparam int TICK_HZ = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int STEPS   = 16;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif
    localparam logic [5:0] SW = 6'b010011;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [10:0] wr_data;
    logic [5:0]  manual_sw;
    logic [5:0]  note_code;
    logic        gate;
    logic        busy;
    logic [3:0]  step_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: a step is one fetch cycle followed by dur*DIV playing cycles.
    logic [10:0] m_mem [STEPS];
    bit          m_busy;
    bit          m_fetch;
    int          m_idx;
    int          m_left;
    int          m_step;
    logic [5:0]  m_note;
    bit          m_gate;
    logic [10:0] m_word;

    melody_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .STEPS   (STEPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .manual_sw (manual_sw),
        .note_code (note_code),
        .gate      (gate),
        .busy      (busy),
        .step_idx  (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic model_cycle();
        m_word = m_mem[m_idx];
        if (!m_busy) begin
            m_note = manual_sw;
            m_gate = 1'b1;
            if (start && !stop) begin
                m_busy  = 1'b1;
                m_fetch = 1'b1;
                m_idx   = 0;
            end
        end else if (stop) begin
            m_busy = 1'b0;
        end else if (m_fetch) begin
            if (m_word[3:0] == 4'd0) begin
                if (m_idx == 0 || !LOOP_EN) m_busy = 1'b0;
                else m_idx = 0;
            end else begin
                m_fetch = 1'b0;
                m_left  = int'(m_word[3:0]) * DIV;
                m_step  = m_idx;
                if (m_word[10]) begin
                    m_gate = 1'b0;
                end else begin
                    m_note = m_word[9:4];
                    m_gate = 1'b1;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_idx == STEPS - 1 && !LOOP_EN) begin
                    m_busy = 1'b0;
                end else begin
                    m_idx   = (m_idx + 1) % STEPS;
                    m_fetch = 1'b1;
                end
            end
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_fetch = 1'b0;
                m_idx   = 0;
                m_left  = 0;
                m_step  = 0;
                m_note  = 6'b000101;
                m_gate  = 1'b0;
                for (int i = 0; i < STEPS; i++) m_mem[i] = '0;
            end else begin
                model_cycle();
            end
        end
    end

    // Every cycle, shortly after the edge, the DUT outputs must equal the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check_output("note_code", 32'(note_code), 32'(m_note));
            check_output("gate", 32'(gate), 32'(m_gate));
            check_output("busy", 32'(busy), 32'(m_busy));
            check_output("step_idx", 32'(step_idx), 32'(m_step[3:0]));
        end
    end

    // Drive one cycle's worth of inputs, then advance to the next falling edge.
    task automatic apply_stimulus(input logic s, input logic p, input logic we,
                                  input logic [3:0] a, input logic [10:0] d, input logic [5:0] sw);
        start     = s;
        stop      = p;
        wr_en     = we;
        wr_addr   = a;
        wr_data   = d;
        manual_sw = sw;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 11'd0, SW);
    endtask

    task automatic write_word(input logic [3:0] a, input logic [10:0] d);
        apply_stimulus(1'b0, 1'b0, 1'b1, a, d, SW);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'd0, 11'd0, SW);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            idle_cycles(1);
            n++;
        end
        n_checks++;
        if (!busy) n_pass++;
        else $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 11'd0;
        manual_sw = SW;
        #1;

        // Reset values, then one-cycle passthrough after release.
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("reset note_code", 32'(note_code), 32'h05);
        check_output("reset gate", 32'(gate), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset step_idx", 32'(step_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("passthrough note_code", 32'(note_code), 32'h13);
        check_output("passthrough gate", 32'(gate), 32'd1);
        check_output("passthrough busy", 32'(busy), 32'd0);

        // Three-step pattern followed by an end marker.
        write_word(4'd0, {1'b0, 6'b000000, 4'd2});
        write_word(4'd1, {1'b1, 6'b000000, 4'd1});
        write_word(4'd2, {1'b0, 6'b100110, 4'd3});
        write_word(4'd3, 11'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 11'd0, SW);
        check_output("three busy rise", 32'(busy), 32'd1);
        idle_cycles(1);
        check_output("three s0 note", 32'(note_code), 32'h00);
        check_output("three s0 gate", 32'(gate), 32'd1);
        check_output("three s0 idx", 32'(step_idx), 32'd0);
        idle_cycles(9);
        check_output("three s1 gate", 32'(gate), 32'd0);
        check_output("three s1 idx", 32'(step_idx), 32'd1);
        idle_cycles(5);
        check_output("three s2 note", 32'(note_code), 32'h26);
        check_output("three s2 gate", 32'(gate), 32'd1);
        check_output("three s2 idx", 32'(step_idx), 32'd2);
        idle_cycles(13);
        check_output("three end busy", 32'(busy), LOOP_EN ? 32'd1 : 32'd0);
        idle_cycles(1);
        check_output("three after note", 32'(note_code), LOOP_EN ? 32'h00 : 32'h13);
        check_output("three after idx", 32'(step_idx), LOOP_EN ? 32'd0 : 32'd2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 11'd0, SW);
        check_output("stop busy", 32'(busy), 32'd0);
        idle_cycles(2);

        // Empty pattern: busy for exactly one cycle.
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 11'd0, SW);
        check_output("empty busy high", 32'(busy), 32'd1);
        idle_cycles(1);
        check_output("empty busy low", 32'(busy), 32'd0);
        idle_cycles(1);
        check_output("empty passthrough", 32'(note_code), 32'h13);

        // Simultaneous start and stop stays idle.
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd0, 11'd0, SW);
        check_output("start+stop busy", 32'(busy), 32'd0);
        idle_cycles(1);
        check_output("start+stop busy later", 32'(busy), 32'd0);

        // Full wrap: sixteen one-tick steps.
        do_reset();
        for (int k = 0; k < STEPS; k++) begin
            write_word(4'(k), {(k % 3 == 2) ? 1'b1 : 1'b0, 6'(k + 1), 4'd1});
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 11'd0, SW);
        idle_cycles(1);
        for (int k = 0; k < STEPS; k++) begin
            check_output("wrap step_idx", 32'(step_idx), 32'(k));
            if (k < STEPS - 1) idle_cycles(5);
        end
        idle_cycles(4);
        check_output("wrap end busy", 32'(busy), LOOP_EN ? 32'd1 : 32'd0);
        idle_cycles(1);
        check_output("wrap restart idx", 32'(step_idx), LOOP_EN ? 32'd0 : 32'd15);
        check_output("wrap restart busy", 32'(busy), LOOP_EN ? 32'd1 : 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 11'd0, SW);
        idle_cycles(2);

        // Write to the fetched address during FETCH: old word now, new word next pass.
        do_reset();
        write_word(4'd0, {1'b0, 6'd10, 4'd1});
        write_word(4'd1, {1'b0, 6'd20, 4'd1});
        write_word(4'd2, 11'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 11'd0, SW);
        apply_stimulus(1'b0, 1'b0, 1'b1, 4'd0, {1'b0, 6'd30, 4'd1}, SW);
        check_output("rbw old word", 32'(note_code), 32'd10);
`ifdef SEQ_LOOP_EN
        idle_cycles(11);
        check_output("rbw new word", 32'(note_code), 32'd30);
        check_output("rbw new idx", 32'(step_idx), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 11'd0, SW);
`else
        wait_idle(50);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd0, 11'd0, SW);
        idle_cycles(1);
        check_output("rbw new word", 32'(note_code), 32'd30);
`endif
        idle_cycles(2);

        // Randomized traffic with an asynchronous reset in the middle.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                #3;
                rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            apply_stimulus($urandom_range(0, 15) == 0,
                           $urandom_range(0, 99) == 0,
                           $urandom_range(0, 5) == 0,
                           4'($urandom),
                           {1'($urandom), 6'($urandom), 4'($urandom_range(0, 3))},
                           6'($urandom));
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd0, 11'd0, SW);
        idle_cycles(3);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
